updown_modn_counter: RTL
========================

Name: updown_modn_counter

Overview:
- Parametrised reversible modulo-N counter with a Mealy carry/borrow output; next generation of the team's 4-state up/down counter FSM.
- Generalises the fixed mod-4 count to any MODULUS and WIDTH.
- Adds count enable, synchronous parallel load, saturate-or-wrap mode and a cascade carry output, so counters chain into multi-digit counters (for example BCD display stages).

Parameters:
- WIDTH, 4, bit width of the count register and load data.
- MODULUS, 10, count range 0..MODULUS-1. Legal range 2 <= MODULUS <= 2**WIDTH; elaboration must fail outside this range.
- RESET_VALUE, 0, count value on reset. Must be < MODULUS.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  count enable.
- A  input  1  direction: 0 = count up, 1 = count down.
- sat  input  1  limit mode: 0 = wrap at the limit, 1 = hold at the limit.
- load  input  1  synchronous parallel load.
- din  input  WIDTH  load data.
- q  output  WIDTH  current count (registered).
- out  output  1  terminal indication (combinational, Mealy).
- cout  output  1  cascade carry/borrow enable (combinational).
- ovf  output  1  sticky overflow flag (see Optional Feature).

Behaviour:
- Clock and reset (already decided): one clock, clk; reset is asynchronous and active-high.
- reset=1: q = RESET_VALUE immediately, with no clock edge required. This also holds mid-count.
- Reset values of the other outputs:
  - out = (A ? RESET_VALUE==0 : RESET_VALUE==MODULUS-1).
  - cout follows its equation below.
  - ovf = 0.
- Next-state priority on each rising edge, when reset=0:
  1. load=1: q <= din if din < MODULUS, else q <= MODULUS-1 (clamp). en is ignored.
  2. en=1, A=0: if q == MODULUS-1 then q <= (sat ? q : 0), else q <= q+1.
  3. en=1, A=1: if q == 0 then q <= (sat ? q : MODULUS-1), else q <= q-1.
  4. Otherwise q holds.
- out = (A==0 && q==MODULUS-1) || (A==1 && q==0).
  - Combinational on q and A; independent of en, load and sat.
- cout = out & en & ~load.
  - One-cycle pulse for each wrap or saturate attempt.
  - Drives en of the next stage for cascading.
- Arithmetic stays within WIDTH bits. No intermediate value may exceed MODULUS-1 or go below 0.
- Direction change (A toggles) takes effect on the next edge. out changes combinationally in the same cycle.
- sat=1 at a limit: q holds, and out and cout still assert.
- When MODULUS == 2**WIDTH, the behaviour must be identical to natural binary wrap.

Optional Feature:
- Macro: UPDOWN_MODN_OVF_STICKY_EN.
- Defined:
  - ovf is a register that sets to 1 on any rising edge where cout=1.
  - It stays 1 until load=1 on an edge (cleared on that edge) or reset=1 (cleared asynchronously).
  - Set and clear on the same edge: clear wins.
- Undefined: no ovf register exists and ovf is tied to 0. All other behaviour is unchanged.

Test Plan (WIDTH=4, MODULUS=10, RESET_VALUE=0):
- Reset: assert reset with A=1, no clock edge -> q=0, out=1, ovf=0. Deassert with A=0 -> out=0.
- Up count: en=1, A=0, sat=0, 12 edges from 0 -> q = 1..9,0,1,2.
  - out=1 only while q=9.
  - cout pulses once, in the cycle where q=9.
  - q=0 follows 9.
- Down count: en=1, A=1 from q=0 -> q=9 after 1 edge, with cout=1 in the cycle before. Then q = 8,7...
- Load: load din=13 -> q=9. Then load=1, en=1, din=5 -> q=5 (load priority). ovf cleared when the macro is defined.
- Saturate: q=9, sat=1, A=0, en=1 for 3 edges -> q stays 9, out=1, cout=1, ovf=1 (macro defined). Then A=1 -> q=8 next edge.
- Asynchronous reset mid-count: q=6, en=1, pulse reset between edges -> q=0 before the next edge. Counting resumes from 0 after release.

Source files
------------

// File: rtl/updown_modn_counter_if.sv
// Control and status bundle for updown_modn_counter.
// The counter side uses the slave modport; whoever drives it uses master.
interface updown_modn_counter_if #(
  parameter int unsigned WIDTH = 4
);
  logic             en;
  logic             A;
  logic             sat;
  logic             load;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] q;
  logic             out;
  logic             cout;
  logic             ovf;

  modport master (
    output en, A, sat, load, din,
    input  q, out, cout, ovf
  );

  modport slave (
    input  en, A, sat, load, din,
    output q, out, cout, ovf
  );
endinterface

// File: rtl/updown_modn_counter.sv
// Reversible modulo-MODULUS counter with a Mealy terminal output and a cascade carry.
// Define UPDOWN_MODN_OVF_STICKY_EN to build the sticky overflow flag; otherwise ovf is tied low.
module updown_modn_counter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MODULUS     = 10,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  updown_modn_counter_if.slave  bus
);

  localparam longint unsigned SPAN  = 64'(1) << WIDTH;
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VALUE);

  // Reject illegal configurations at elaboration time.
  if (MODULUS < 2 || 64'(MODULUS) > SPAN) begin : g_bad_modulus
    $error("updown_modn_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (RESET_VALUE >= MODULUS) begin : g_bad_reset_value
    $error("updown_modn_counter: RESET_VALUE must be below MODULUS");
  end

  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] q_next;
  logic             out_c;
  logic             cout_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_r <= RST_Q;
    else       q_r <= q_next;
  end

  // Load beats counting; limits either wrap or hold, never leaving 0..MODULUS-1.
  always_comb begin
    q_next = q_r;
    if (bus.load) begin
      q_next = (bus.din > MAX_Q) ? MAX_Q : bus.din;
    end else if (bus.en) begin
      if (!bus.A) begin
        if (q_r == MAX_Q) q_next = bus.sat ? q_r : '0;
        else              q_next = q_r + WIDTH'(1);
      end else begin
        if (q_r == '0)    q_next = bus.sat ? q_r : MAX_Q;
        else              q_next = q_r - WIDTH'(1);
      end
    end
  end

  always_comb begin
    out_c  = bus.A ? (q_r == '0) : (q_r == MAX_Q);
    cout_c = out_c & bus.en & ~bus.load;
  end

  assign bus.q    = q_r;
  assign bus.out  = out_c;
  assign bus.cout = cout_c;

`ifdef UPDOWN_MODN_OVF_STICKY_EN
  logic ovf_r;

  // Load clears before a same-edge carry can set it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ovf_r <= 1'b0;
    else if (bus.load) ovf_r <= 1'b0;
    else if (cout_c) ovf_r <= 1'b1;
  end

  assign bus.ovf = ovf_r;
`else
  assign bus.ovf = 1'b0;
`endif

endmodule
